regfile_sb: RTL and testbench

//  Parametrised register file with 2 async read ports, 2 write-back ports, same-cycle

---
 rtl/regfile_sb.sv | 148 ++++++++++++++
 tb/tb_regfile_sb.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb
//   Register file with two combinational read ports, two write-back ports,
//   same-cycle write-to-read bypass and a busy scoreboard that tracks
//   registers with an in-flight producer. Decode reads and issues on one
//   side; ALU (port 0) and memory (port 1) write back on the other.
//
// Parameters
//   DATA_W    register width
//   NUM_REGS  register count (power of 2, >= 2)
//   ZERO_REG  1: register 0 is hard-wired to zero and never becomes busy
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   rd_addr1/2               read addresses
//   rd_data1/2               read data, bypassed from this cycle's write-back
//   rd_busy1/2               addressed register still awaits its producer
//   wr_en0/1, wr_addr0/1,
//   wr_data0/1               write-back ports (port 1 wins on same address)
//   issue_en, issue_addr     mark a destination register busy
//   flush                    clear every busy bit, data untouched
//   busy_cnt                 registered count of busy registers

module regfile_sb #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter bit ZERO_REG = 1'b0,
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] rd_addr1,
    output logic [DATA_W-1:0] rd_data1,
    output logic              rd_busy1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_busy2,

    input  logic              wr_en0,
    input  logic [ADDR_W-1:0] wr_addr0,
    input  logic [DATA_W-1:0] wr_data0,
    input  logic              wr_en1,
    input  logic [ADDR_W-1:0] wr_addr1,
    input  logic [DATA_W-1:0] wr_data1,

    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic              flush,

    output logic [ADDR_W:0]   busy_cnt
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nxt;
    logic [ADDR_W:0]     cnt_nxt;

    logic we0_eff;
    logic we1_eff;
    logic issue_eff;

    // With a hard-wired zero register, anything aimed at address 0 is
    // dropped right here so neither storage nor scoreboard ever sees it.
    always_comb begin
        we0_eff   = wr_en0;
        we1_eff   = wr_en1;
        issue_eff = issue_en;
        if (ZERO_REG) begin
            if (wr_addr0 == '0)   we0_eff   = 1'b0;
            if (wr_addr1 == '0)   we1_eff   = 1'b0;
            if (issue_addr == '0) issue_eff = 1'b0;
        end
    end

    // Storage. Port 1 is applied last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (we0_eff) regs[wr_addr0] <= wr_data0;
            if (we1_eff) regs[wr_addr1] <= wr_data1;
        end
    end

    // Read port 1: later assignments carry higher priority.
    always_comb begin
        rd_data1 = regs[rd_addr1];
        if (we0_eff && (wr_addr0 == rd_addr1)) rd_data1 = wr_data0;
        if (we1_eff && (wr_addr1 == rd_addr1)) rd_data1 = wr_data1;
        if (ZERO_REG && (rd_addr1 == '0))      rd_data1 = '0;
    end

    // Read port 2: same priority as port 1.
    always_comb begin
        rd_data2 = regs[rd_addr2];
        if (we0_eff && (wr_addr0 == rd_addr2)) rd_data2 = wr_data0;
        if (we1_eff && (wr_addr1 == rd_addr2)) rd_data2 = wr_data1;
        if (ZERO_REG && (rd_addr2 == '0))      rd_data2 = '0;
    end

    // A register being written this cycle already has its value on the
    // bypass path, so it no longer needs to stall the reader. A same-cycle
    // issue only shows up once the busy bit is registered.
    always_comb begin
        rd_busy1 = busy[rd_addr1];
        if (we0_eff && (wr_addr0 == rd_addr1)) rd_busy1 = 1'b0;
        if (we1_eff && (wr_addr1 == rd_addr1)) rd_busy1 = 1'b0;

        rd_busy2 = busy[rd_addr2];
        if (we0_eff && (wr_addr0 == rd_addr2)) rd_busy2 = 1'b0;
        if (we1_eff && (wr_addr1 == rd_addr2)) rd_busy2 = 1'b0;
    end

    // Scoreboard update order: write-back clears first, then issue sets, so
    // a new producer issued alongside the old one's write-back stays pending.
    // Flush discards everything including this cycle's issue.
    always_comb begin
        busy_nxt = busy;
        if (we0_eff) busy_nxt[wr_addr0] = 1'b0;
        if (we1_eff) busy_nxt[wr_addr1] = 1'b0;
        if (flush) begin
            busy_nxt = '0;
        end else if (issue_eff) begin
            busy_nxt[issue_addr] = 1'b1;
        end
    end

    // ADDR_W+1 bits hold NUM_REGS exactly, so the count cannot wrap.
    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, busy_nxt[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  rd_addr1, rd_addr2;
    logic        wr_en0, wr_en1, issue_en, flush;
    logic [2:0]  wr_addr0, wr_addr1, issue_addr;
    logic [15:0] wr_data0, wr_data1;

    logic [15:0] rd_data1, rd_data2, z_rd_data1, z_rd_data2;
    logic        rd_busy1, rd_busy2, z_rd_busy1, z_rd_busy2;
    logic [3:0]  busy_cnt, z_busy_cnt;

    always #5 clk = ~clk;

    regfile_sb #(.DATA_W(16), .NUM_REGS(8), .ZERO_REG(1'b0)) dut (
        .clk(clk), .rst(rst),
        .rd_addr1(rd_addr1), .rd_data1(rd_data1), .rd_busy1(rd_busy1),
        .rd_addr2(rd_addr2), .rd_data2(rd_data2), .rd_busy2(rd_busy2),
        .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
        .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
        .issue_en(issue_en), .issue_addr(issue_addr), .flush(flush),
        .busy_cnt(busy_cnt)
    );

    regfile_sb #(.DATA_W(16), .NUM_REGS(8), .ZERO_REG(1'b1)) dut_z (
        .clk(clk), .rst(rst),
        .rd_addr1(rd_addr1), .rd_data1(z_rd_data1), .rd_busy1(z_rd_busy1),
        .rd_addr2(rd_addr2), .rd_data2(z_rd_data2), .rd_busy2(z_rd_busy2),
        .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
        .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
        .issue_en(issue_en), .issue_addr(issue_addr), .flush(flush),
        .busy_cnt(z_busy_cnt)
    );

    typedef struct packed {
        logic        we0; logic [2:0] wa0; logic [15:0] wd0;
        logic        we1; logic [2:0] wa1; logic [15:0] wd1;
        logic        ie;  logic [2:0] ia;  logic fl;
        logic [2:0]  ra1; logic [2:0] ra2;
        logic [15:0] e_rd1; logic e_b1; logic [15:0] e_rd2; logic e_b2; logic [3:0] e_cnt;
    } vec_t;

    typedef struct packed {
        logic        z;
        logic [15:0] tag;
        logic [15:0] rd1; logic b1; logic [15:0] rd2; logic b2; logic [3:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   tag    = 0;

    function automatic vec_t mk(
        input logic we0, input logic [2:0] wa0, input logic [15:0] wd0,
        input logic we1, input logic [2:0] wa1, input logic [15:0] wd1,
        input logic ie, input logic [2:0] ia, input logic fl,
        input logic [2:0] ra1, input logic [2:0] ra2,
        input logic [15:0] e_rd1, input logic e_b1,
        input logic [15:0] e_rd2, input logic e_b2, input logic [3:0] e_cnt);
        vec_t v;
        v.we0 = we0; v.wa0 = wa0; v.wd0 = wd0;
        v.we1 = we1; v.wa1 = wa1; v.wd1 = wd1;
        v.ie = ie; v.ia = ia; v.fl = fl; v.ra1 = ra1; v.ra2 = ra2;
        v.e_rd1 = e_rd1; v.e_b1 = e_b1; v.e_rd2 = e_rd2; v.e_b2 = e_b2; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst = 1'b0;
        wr_en0 = v.we0; wr_addr0 = v.wa0; wr_data0 = v.wd0;
        wr_en1 = v.we1; wr_addr1 = v.wa1; wr_data1 = v.wd1;
        issue_en = v.ie; issue_addr = v.ia; flush = v.fl;
        rd_addr1 = v.ra1; rd_addr2 = v.ra2;
    endtask

    task automatic push(input logic z, input logic [15:0] rd1, input logic b1,
                        input logic [15:0] rd2, input logic b2, input logic [3:0] cnt);
        exp_t e;
        e.z = z; e.tag = 16'(tag);
        e.rd1 = rd1; e.b1 = b1; e.rd2 = rd2; e.b2 = b2; e.cnt = cnt;
        sb.push_back(e);
    endtask

    // Drive v, queue its expectations for the ZERO_REG=0 instance.
    task automatic apply(input vec_t v);
        drive(v);
        push(1'b0, v.e_rd1, v.e_b1, v.e_rd2, v.e_b2, v.e_cnt);
    endtask

    // Compare every queued expectation mid-cycle, then advance one clock.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_empty: got 0 entries expected >=1 at step %0d", tag);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.z) begin
                cmp($sformatf("z%0d rd_data1", e.tag), z_rd_data1, e.rd1);
                cmp($sformatf("z%0d rd_busy1", e.tag), 16'(z_rd_busy1), 16'(e.b1));
                cmp($sformatf("z%0d rd_data2", e.tag), z_rd_data2, e.rd2);
                cmp($sformatf("z%0d rd_busy2", e.tag), 16'(z_rd_busy2), 16'(e.b2));
                cmp($sformatf("z%0d busy_cnt", e.tag), 16'(z_busy_cnt), 16'(e.cnt));
            end else begin
                cmp($sformatf("t%0d rd_data1", e.tag), rd_data1, e.rd1);
                cmp($sformatf("t%0d rd_busy1", e.tag), 16'(rd_busy1), 16'(e.b1));
                cmp($sformatf("t%0d rd_data2", e.tag), rd_data2, e.rd2);
                cmp($sformatf("t%0d rd_busy2", e.tag), 16'(rd_busy2), 16'(e.b2));
                cmp($sformatf("t%0d busy_cnt", e.tag), 16'(busy_cnt), 16'(e.cnt));
            end
        end
        tag++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected summary");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        vecs[$];
        vec_t        v;
        logic [15:0] mexp [8];

        rst = 1'b1;
        wr_en0 = 0; wr_en1 = 0; issue_en = 0; flush = 0;
        wr_addr0 = 0; wr_addr1 = 0; issue_addr = 0;
        wr_data0 = 0; wr_data1 = 0; rd_addr1 = 0; rd_addr2 = 0;
        repeat (2) @(posedge clk);
        #1;

        // Random traffic to leave non-zero state behind.
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wr_en0 = 1'b1; wr_addr0 = 3'(i); wr_data0 = 16'($urandom_range(1, 16'hFFFF));
            wr_en1 = 1'($urandom_range(0, 1)); wr_addr1 = 3'($urandom_range(0, 7));
            wr_data1 = 16'($urandom_range(1, 16'hFFFF));
            issue_en = 1'b1; issue_addr = 3'((i + 3) % 8);
            @(posedge clk);
            #1;
        end

        // Reset cycle carrying a write and an issue that must both be ignored.
        rst = 1'b1;
        wr_en0 = 1'b1; wr_addr0 = 3'd3; wr_data0 = 16'h5555;
        wr_en1 = 1'b0; issue_en = 1'b1; issue_addr = 3'd4;
        @(posedge clk);
        #1;

        for (int i = 0; i < 4; i++) begin
            apply(mk(0,0,0, 0,0,0, 0,0,0, 3'(i), 3'(i + 4), 16'h0,0, 16'h0,0, 4'd0));
            push(1'b1, 16'h0, 0, 16'h0, 0, 4'd0);
            tick();
        end

        //          we0 wa0 wd0       we1 wa1 wd1       ie ia fl ra1 ra2  rd1      b1 rd2      b2 cnt
        vecs.push_back(mk(1, 3, 16'h1234, 1, 3, 16'hBEEF, 0, 0, 0, 3, 4, 16'hBEEF, 0, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 3, 3, 16'hBEEF, 0, 16'hBEEF, 0, 0));
        vecs.push_back(mk(1, 6, 16'h0042, 0, 0, 16'h0000, 0, 0, 0, 6, 3, 16'h0042, 0, 16'hBEEF, 0, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 6, 0, 16'h0042, 0, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 5, 0, 5, 6, 16'h0000, 0, 16'h0042, 0, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 5, 5, 16'h0000, 1, 16'h0000, 1, 1));
        vecs.push_back(mk(1, 5, 16'h00AA, 0, 0, 16'h0000, 0, 0, 0, 5, 3, 16'h00AA, 0, 16'hBEEF, 0, 1));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 5, 5, 16'h00AA, 0, 16'h00AA, 0, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 1, 2, 16'h7777, 1, 2, 0, 2, 1, 16'h7777, 0, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 2, 2, 16'h7777, 1, 16'h7777, 1, 1));
        vecs.push_back(mk(0, 0, 16'h0000, 1, 2, 16'h2222, 1, 7, 0, 2, 7, 16'h2222, 0, 16'h0000, 0, 1));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 2, 7, 16'h2222, 0, 16'h0000, 1, 1));
        vecs.push_back(mk(1, 7, 16'h0707, 1, 1, 16'h0101, 0, 0, 0, 7, 1, 16'h0707, 0, 16'h0101, 0, 1));
        vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 7, 1, 16'h0707, 0, 16'h0101, 0, 0));

        foreach (vecs[i]) begin
            apply(vecs[i]);
            tick();
        end

        // Fill the whole scoreboard one issue per cycle.
        mexp[0] = 16'h0000; mexp[1] = 16'h0101; mexp[2] = 16'h2222; mexp[3] = 16'hBEEF;
        mexp[4] = 16'h0000; mexp[5] = 16'h00AA; mexp[6] = 16'h0042; mexp[7] = 16'h0707;
        for (int i = 0; i < 8; i++) begin
            v = mk(0,0,0, 0,0,0, 1, 3'(i), 0, 3'(i), 3'((i + 7) % 8),
                   mexp[i], 0, mexp[(i + 7) % 8], (i > 0), 4'(i));
            apply(v);
            tick();
        end
        // Re-issuing an already busy register must not push the count past 8.
        apply(mk(0,0,0, 0,0,0, 1,3,0, 0,7, mexp[0],1, mexp[7],1, 4'd8));
        tick();
        apply(mk(0,0,0, 0,0,0, 1,1,1, 1,3, mexp[1],1, mexp[3],1, 4'd8));
        tick();
        apply(mk(0,0,0, 0,0,0, 0,0,0, 1,3, mexp[1],0, mexp[3],0, 4'd0));
        tick();

        // Register 0 behaviour, hard-wired instance against the plain one.
        apply(mk(0,0,0, 0,0,0, 1,4,0, 4,0, 16'h0000,0, 16'h0000,0, 4'd0));
        push(1'b1, 16'h0000, 0, 16'h0000, 0, 4'd0);
        tick();
        apply(mk(1,0,16'hFFFF, 0,0,0, 1,0,0, 0,4, 16'hFFFF,0, 16'h0000,1, 4'd1));
        push(1'b1, 16'h0000, 0, 16'h0000, 1, 4'd1);
        tick();
        apply(mk(0,0,0, 0,0,0, 0,0,0, 0,4, 16'hFFFF,1, 16'h0000,1, 4'd2));
        push(1'b1, 16'h0000, 0, 16'h0000, 1, 4'd1);
        tick();
        apply(mk(1,6,16'h6666, 1,0,16'h1111, 0,0,0, 0,6, 16'h1111,0, 16'h6666,0, 4'd2));
        push(1'b1, 16'h0000, 0, 16'h6666, 0, 4'd1);
        tick();
        apply(mk(0,0,0, 0,0,0, 0,0,0, 0,6, 16'h1111,0, 16'h6666,0, 4'd1));
        push(1'b1, 16'h0000, 0, 16'h6666, 0, 4'd1);
        tick();

        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL sb_drain: got %0d entries expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
